// File: rtl/alu32_pkg.sv
// alu32_pkg: shared opcode encoding and default data-path width for the alu32 slice
//   WIDTH_DEFAULT : default data-path width
//   alu_op_e      : ALUctl opcode encoding
package alu32_pkg;
    localparam int WIDTH_DEFAULT = 32;
    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_NOR  = 4'b1100,
        OP_NAND = 4'b1101
    } alu_op_e;
endpackage

// File: rtl/alu32_addsub.sv
// alu32_addsub: combinational adder/subtractor with signed overflow and signed less-than
//   a, b     : operands (two's complement)
//   sub      : 1 selects a - b (a + ~b + 1), 0 selects a + b
//   sum      : result modulo 2^WIDTH
//   overflow : signed overflow of the selected operation
//   less     : a < b as signed, valid when sub is 1
module alu32_addsub
    import alu32_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             overflow,
    output logic             less
);
    logic [WIDTH-1:0] b_eff;
    assign b_eff    = sub ? ~b : b;
    assign sum      = a + b_eff + {{(WIDTH-1){1'b0}}, sub};
    // overflow: operands agree in sign but the sum does not
    assign overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    // a wrapped difference flips the sign bit, so correct it with the overflow flag
    assign less     = sum[WIDTH-1] ^ overflow;
endmodule

// File: rtl/alu32.sv
// alu32: registered 32-bit ALU with one-cycle latency, signed overflow and zero flags
//   clk      : clock, all state updates on rising edge
//   rst_n    : synchronous active-low reset (result 0, overflow 0, zero 1)
//   A, B     : operands
//   ALUctl   : opcode (see alu32_pkg::alu_op_e); undefined codes give 0
//   result   : registered result
//   overflow : registered signed overflow, only for ADD/SUB
//   zero     : registered result == 0
module alu32
    import alu32_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUctl,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             zero
);
    logic             sub;
    logic [WIDTH-1:0] sum;
    logic             as_ovf;
    logic             less;
    logic [WIDTH-1:0] result_next;
    logic             overflow_next;

    // SLT reuses the subtractor
    assign sub = (ALUctl == OP_SUB) || (ALUctl == OP_SLT);

    alu32_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a        (A),
        .b        (B),
        .sub      (sub),
        .sum      (sum),
        .overflow (as_ovf),
        .less     (less)
    );

    always_comb begin
        result_next   = '0;
        overflow_next = 1'b0;
        case (ALUctl)
            OP_AND:  result_next = A & B;
            OP_OR:   result_next = A | B;
            OP_NOR:  result_next = ~(A | B);
            OP_NAND: result_next = ~(A & B);
            OP_ADD, OP_SUB: begin
                result_next   = sum;
                overflow_next = as_ovf;
            end
            OP_SLT:  result_next = {{(WIDTH-1){1'b0}}, less};
            default: result_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result   <= '0;
            overflow <= 1'b0;
            zero     <= 1'b1;
        end else begin
            result   <= result_next;
            overflow <= overflow_next;
            zero     <= (result_next == '0);
        end
    end
endmodule

// File: tb/tb_alu32.sv
// tb_alu32: directed self-checking bench for alu32 with hand-computed expectations
module tb_alu32;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [3:0]  ALUctl = '0;
    logic [31:0] result;
    logic        overflow;
    logic        zero;
    int          checks = 0;
    int          errors = 0;

    alu32 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .A        (A),
        .B        (B),
        .ALUctl   (ALUctl),
        .result   (result),
        .overflow (overflow),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("%s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // drive one operation, clock it in, check all three outputs one edge later
    task automatic step(input string tag, input logic r, input logic [3:0] c,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic eo, input logic ez);
        rst_n = r; ALUctl = c; A = a; B = b;
        @(posedge clk);
        #1;
        check({tag, ".result"}, result, er);
        check({tag, ".overflow"}, {31'b0, overflow}, {31'b0, eo});
        check({tag, ".zero"}, {31'b0, zero}, {31'b0, ez});
    endtask

    initial begin
        step("reset",      1'b0, 4'b0010, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1);
        step("add_ovf_p",  1'b1, 4'b0010, 32'h4000_0000, 32'h4000_0000, 32'h8000_0000, 1'b1, 1'b0);
        step("add_ovf_n",  1'b1, 4'b0010, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1);
        step("add_m1m1",   1'b1, 4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0);
        step("sub_ovf",    1'b1, 4'b0110, 32'hAAAA_AAAA, 32'h5555_5555, 32'h5555_5555, 1'b1, 1'b0);
        step("sub_neg",    1'b1, 4'b0110, 32'h0000_0000, 32'h4000_0000, 32'hC000_0000, 1'b0, 1'b0);
        step("sub_min",    1'b1, 4'b0110, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b1);
        step("sub_c0_80",  1'b1, 4'b0110, 32'hC000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 1'b0);
        step("sub_0_m1",   1'b1, 4'b0110, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        step("slt_80_c0",  1'b1, 4'b0111, 32'h8000_0000, 32'hC000_0000, 32'h0000_0001, 1'b0, 1'b0);
        step("slt_m1_0",   1'b1, 4'b0111, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0);
        step("slt_0_m1",   1'b1, 4'b0111, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1);
        step("slt_aa_15",  1'b1, 4'b0111, 32'hAAAA_AAAA, 32'h1555_5555, 32'h0000_0001, 1'b0, 1'b0);
        step("slt_min_1",  1'b1, 4'b0111, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
        step("slt_max_m1", 1'b1, 4'b0111, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1);
        step("nor",        1'b1, 4'b1100, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000, 1'b0, 1'b1);
        step("nand",       1'b1, 4'b1101, 32'hC000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0);
        step("or",         1'b1, 4'b0001, 32'h0000_0000, 32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0);
        step("and",        1'b1, 4'b0000, 32'hC000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        step("undef_3",    1'b1, 4'b0011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1);
        step("undef_f",    1'b1, 4'b1111, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000, 1'b0, 1'b1);
        step("add_pre",    1'b1, 4'b0010, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0);
        step("mid_reset",  1'b0, 4'b0010, 32'h4000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b1);
        step("add_post",   1'b1, 4'b0010, 32'h0000_0005, 32'h0000_0006, 32'h0000_000B, 1'b0, 1'b0);
        step("sub_post",   1'b1, 4'b0110, 32'h0000_0005, 32'h0000_0006, 32'hFFFF_FFFF, 1'b0, 1'b0);
        // outputs must hold between edges
        @(negedge clk);
        check("hold.result", result, 32'hFFFF_FFFF);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
